serial_sub16: RTL and testbench

Multi-cycle subtractor that computes `a - b - bin` one slice per clock, LSB first, rippling a borrow through a registered full-subtractor chain. It is the subtraction counterpart of the 16-bit ripple adder. Arithmetic units in the datapath use it when a narrow, area-cheap subtract path is preferred over a wide combinational one. A start/done handshake lets a controller issue back-to-back operations.

---
 rtl/serial_sub16_pkg.sv | 12 +
 rtl/serial_sub_slice.sv | 26 ++
 rtl/serial_sub16.sv | 127 ++++++++++++
 tb/tb_serial_sub16.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub16_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    localparam int unsigned SUB_WIDTH_DEF = 16;

endpackage

// File: rtl/serial_sub_slice.sv
// Combinational BPC-bit ripple full-subtractor chain, LSB first.
module serial_sub_slice #(
    parameter int unsigned BPC = 1
) (
    input  logic [BPC-1:0] x,
    input  logic [BPC-1:0] y,
    input  logic           br_in,
    output logic [BPC-1:0] d,
    output logic           br_out
);

    logic [BPC:0] br_chain;

    always_comb begin
        br_chain    = '0;
        d           = '0;
        br_chain[0] = br_in;
        for (int unsigned i = 0; i < BPC; i++) begin
            d[i]          = x[i] ^ y[i] ^ br_chain[i];
            br_chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br_chain[i]);
        end
    end

    assign br_out = br_chain[BPC];

endmodule

// File: rtl/serial_sub16.sv
// Multi-cycle subtractor: a - b - bin, BPC bits per clock with a registered borrow.
// Optional signed-overflow output enabled by macro SERIAL_SUB16_OVF_EN.
module serial_sub16
    import serial_sub16_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB16_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / BPC;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    sub_state_t state, state_next;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_sr_next;
    logic             br;
    logic [BPC-1:0]   sl_d;
    logic             sl_br;
`ifdef SERIAL_SUB16_OVF_EN
    logic             a_msb, b_msb;
`endif

    assign last = (cnt == CW'(N - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    serial_sub_slice #(
        .BPC(BPC)
    ) u_slice (
        .x     (a_sr[BPC-1:0]),
        .y     (b_sr[BPC-1:0]),
        .br_in (br),
        .d     (sl_d),
        .br_out(sl_br)
    );

    // Result bits enter at the top so the last slice lands in place after N shifts.
    assign d_sr_next = (d_sr >> BPC) | (WIDTH'(sl_d) << (WIDTH - BPC));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB16_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            cnt  <= '0;
            a_sr <= a;
            b_sr <= b;
            d_sr <= '0;
            br   <= bin;
`ifdef SERIAL_SUB16_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            cnt  <= cnt + CW'(1);
            a_sr <= a_sr >> BPC;
            b_sr <= b_sr >> BPC;
            d_sr <= d_sr_next;
            br   <= sl_br;
            if (last) begin
                diff <= d_sr_next;
                bout <= sl_br;
`ifdef SERIAL_SUB16_OVF_EN
                ovf  <= (a_msb != b_msb) && (d_sr_next[WIDTH-1] != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: BPC=1 and BPC=4 instances against a countdown model.
module tb_serial_sub16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        bin;

    logic        busy1, done1, bout1, busy4, done4, bout4;
    logic [15:0] diff1, diff4;
    logic        ovf1, ovf4;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_sub16 #(.WIDTH(16), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB16_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_sub16 #(.WIDTH(16), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB16_OVF_EN
        , .ovf(ovf4)
`endif
    );

`ifndef SERIAL_SUB16_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf4 = 1'b0;
`endif

    // Model: each instance counts down N cycles from acceptance, then shows the arithmetic result.
    int          rem       [2];
    int          nn        [2] = '{16, 4};
    logic        exp_done  [2];
    logic [15:0] exp_diff  [2];
    logic        exp_bout  [2];
    logic        exp_ovf   [2];
    logic [15:0] pend_diff [2];
    logic        pend_bout [2];
    logic        pend_ovf  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rem[i]      <= 0;
                exp_done[i] <= 1'b0;
                exp_diff[i] <= '0;
                exp_bout[i] <= 1'b0;
                exp_ovf[i]  <= 1'b0;
            end else if (rem[i] > 0) begin
                rem[i]      <= rem[i] - 1;
                exp_done[i] <= (rem[i] == 1);
                if (rem[i] == 1) begin
                    exp_diff[i] <= pend_diff[i];
                    exp_bout[i] <= pend_bout[i];
                    exp_ovf[i]  <= pend_ovf[i];
                end
            end else begin
                exp_done[i] <= 1'b0;
                if (start) begin
                    int          da, db, r;
                    logic [15:0] rd;
                    da = int'(a);
                    db = int'(b);
                    r  = da - db - int'(bin);
                    rd = r[15:0];
                    rem[i]       <= nn[i];
                    pend_diff[i] <= rd;
                    pend_bout[i] <= (da < db + int'(bin));
                    pend_ovf[i]  <= (a[15] != b[15]) && (rd[15] != a[15]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy1", 32'(busy1), 32'(rem[0] > 0));
            chk("done1", 32'(done1), 32'(exp_done[0]));
            chk("diff1", 32'(diff1), 32'(exp_diff[0]));
            chk("bout1", 32'(bout1), 32'(exp_bout[0]));
            chk("busy4", 32'(busy4), 32'(rem[1] > 0));
            chk("done4", 32'(done4), 32'(exp_done[1]));
            chk("diff4", 32'(diff4), 32'(exp_diff[1]));
            chk("bout4", 32'(bout4), 32'(exp_bout[1]));
`ifdef SERIAL_SUB16_OVF_EN
            chk("ovf1", 32'(ovf1), 32'(exp_ovf[0]));
            chk("ovf4", 32'(ovf4), 32'(exp_ovf[1]));
`endif
        end
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; bin = tbin;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int sel, input string nm, input logic [15:0] ed,
                             input logic eb, input logic eo);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if ((sel == 0) ? done1 : done4) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: no done within 40 cycles", nm);
        end else begin
            chk({nm, "_diff"}, 32'((sel == 0) ? diff1 : diff4), 32'(ed));
            chk({nm, "_bout"}, 32'((sel == 0) ? bout1 : bout4), 32'(eb));
`ifdef SERIAL_SUB16_OVF_EN
            chk({nm, "_ovf"}, 32'((sel == 0) ? ovf1 : ovf4), 32'(eo));
`else
            if (eo) begin end
`endif
        end
    endtask

    initial begin
        int cnt_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_diff", 32'(diff1), 32'd0);

        issue(16'h0005, 16'h0003, 1'b0);
        wait_done(0, "5m3", 16'h0002, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        issue(16'h0000, 16'h0001, 1'b0);
        wait_done(0, "0m1", 16'hFFFF, 1'b1, 1'b0);
        issue(16'h1234, 16'h1234, 1'b1);
        wait_done(0, "eq_bin", 16'hFFFF, 1'b1, 1'b0);

        issue(16'h8000, 16'h0001, 1'b0);
        wait_done(0, "ovf_hi", 16'h7FFF, 1'b0, 1'b1);
        issue(16'h0003, 16'h0001, 1'b0);
        wait_done(0, "ovf_lo", 16'h0002, 1'b0, 1'b0);

        issue(16'hA5A5, 16'h5A5A, 1'b0);
        wait_done(1, "bpc4", 16'h4B4B, 1'b0, 1'b1);
        wait_done(0, "bpc1", 16'h4B4B, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Second start lands in RUN cycle 5 of the BPC=1 instance.
        issue(16'h1111, 16'h0222, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, "ign_start", 16'h0EEF, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        @(negedge clk);
        start = 1'b1; a = 16'h0010; b = 16'h0020; bin = 1'b0;
        cnt_done = 0;
        for (int k = 0; k < 51; k++) begin
            @(negedge clk);
            if (done1) cnt_done++;
        end
        start = 1'b0;
        chk("held_done_cnt", 32'(cnt_done), 32'd3);
        chk("held_diff", 32'(diff1), 32'h0000FFF0);
        repeat (20) @(negedge clk);

        issue(16'h7777, 16'h1111, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_done", 32'(done1), 32'd0);
        chk("abort_diff", 32'(diff1), 32'd0);
        chk("abort_diff4", 32'(diff4), 32'd0);
        rst = 1'b0;
        cnt_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done1) cnt_done++;
        end
        chk("abort_no_done", 32'(cnt_done), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
